// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin scheduler sharing one 32-bit ALU among NREQ requesters
//
// Accepts one operation at a time from NREQ requesters and drives the shared ALU
// for exactly one cycle. It then returns the registered result and flags,
// tagged with the requester index.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid / req_ready    per-requester handshake; req_ready is one-hot and only in IDLE
//   req_opcode, req_a, req_b packed per-requester opcode (3b each) and operands (32b each)
//   alu_enable/opcode/a/b    drive to the external shared ALU
//   alu_res, alu_zf, alu_cf  combinational ALU outputs sampled at the end of EXEC
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_res,
//   rsp_zf, rsp_cf           captured owner index, result and flags
//   busy                     high whenever an operation is in flight
module alu_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [3*NREQ-1:0]    req_opcode,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 alu_enable,
  output logic [2:0]           alu_opcode,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  input  logic [32:0]          alu_res,
  input  logic                 alu_zf,
  input  logic                 alu_cf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [32:0]          rsp_res,
  output logic                 rsp_zf,
  output logic                 rsp_cf,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            take;

  logic [2:0]      op_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [ID_W-1:0] id_q;

  // Unpacked views of the packed request buses so the winner can be selected
  // with a plain array index.
  logic [2:0]      op_arr [NREQ];
  logic [31:0]     a_arr  [NREQ];
  logic [31:0]     b_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_arr[gi] = req_opcode[3*gi +: 3];
    assign a_arr[gi]  = req_a[32*gi +: 32];
    assign b_arr[gi]  = req_b[32*gi +: 32];
  end

  // Candidate index k positions after base, wrapping at NREQ (NREQ need not be
  // a power of two, so a plain ID_W-bit add is not enough).
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) begin
      s = s - NREQ;
    end
    return s[ID_W-1:0];
  endfunction

  // Arbitration: first valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = rr_index(ptr, k);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and outputs
  always_comb begin
    state_next = state;
    req_ready  = '0;
    alu_enable = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (found) begin
          req_ready[grant] = 1'b1;
          state_next       = EXEC;
        end
      end
      EXEC: begin
        alu_enable = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        // rsp_valid is always set in RESP, so rsp_ready alone completes the handshake.
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign take = (state == IDLE) && found;

  // Operand latch, pointer and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_res   <= '0;
      rsp_zf    <= 1'b0;
      rsp_cf    <= 1'b0;
    end else begin
      if (take) begin
        op_q <= op_arr[grant];
        a_q  <= a_arr[grant];
        b_q  <= b_arr[grant];
        id_q <= grant;
        ptr  <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
      if (state == EXEC) begin
        rsp_res   <= alu_res;
        rsp_zf    <= alu_zf;
        rsp_cf    <= alu_cf;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - directed self-checking bench for alu_rr_scheduler
module tb_alu_rr_scheduler;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [3*NREQ-1:0]    req_opcode;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 alu_enable;
  logic [2:0]           alu_opcode;
  logic [31:0]          alu_a;
  logic [31:0]          alu_b;
  logic [32:0]          alu_res;
  logic                 alu_zf;
  logic                 alu_cf;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [32:0]          rsp_res;
  logic                 rsp_zf;
  logic                 rsp_cf;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  alu_rr_scheduler #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .alu_enable (alu_enable),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_res    (alu_res),
    .alu_zf     (alu_zf),
    .alu_cf     (alu_cf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_res    (rsp_res),
    .rsp_zf     (rsp_zf),
    .rsp_cf     (rsp_cf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external shared ALU
  always_comb begin
    alu_res = '0;
    case (alu_opcode)
      3'b000: alu_res = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010: alu_res = {1'b0, alu_a} + 33'd1;
      3'b011: alu_res = {1'b0, alu_a} - 33'd1;
      3'b100: alu_res = {1'b0, alu_a & alu_b};
      3'b101: alu_res = {1'b0, alu_a | alu_b};
      3'b110: alu_res = {1'b0, ~alu_a};
      default: alu_res = {1'b0, alu_a ^ alu_b};
    endcase
  end
  assign alu_zf = (alu_res == 33'd0);
  assign alu_cf = alu_res[32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_opcode[3*i +: 3] = op;
    req_a[32*i +: 32]    = a;
    req_b[32*i +: 32]    = b;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Entered just after a rising edge in IDLE with rsp_ready=1; returns just
  // after the edge that brings the FSM back to IDLE (3 cycles later).
  task automatic run_op(input logic [3:0] mask, input int exp_id, input logic [32:0] exp_res,
                        input logic exp_zf, input logic exp_cf);
    logic [3:0] onehot;
    onehot    = 4'b0001 << exp_id;
    req_valid = mask;
    @(negedge clk);
    check("grant", {60'd0, req_ready}, {60'd0, onehot});
    cycle();
    @(negedge clk);
    check("exec_enable", {63'd0, alu_enable}, 64'd1);
    check("exec_ready", {60'd0, req_ready}, 64'd0);
    cycle();
    @(negedge clk);
    check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("rsp_id", {62'd0, rsp_id}, exp_id);
    check("rsp_res", {31'd0, rsp_res}, {31'd0, exp_res});
    check("rsp_zf", {63'd0, rsp_zf}, {63'd0, exp_zf});
    check("rsp_cf", {63'd0, rsp_cf}, {63'd0, exp_cf});
    cycle();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_enable", {63'd0, alu_enable}, 64'd0);
    check("rst_ready", {60'd0, req_ready}, 64'd0);
    check("rst_rsp_res", {31'd0, rsp_res}, 64'd0);
    check("rst_alu_a", {32'd0, alu_a}, 64'd0);
    cycle();

    set_req(0, 3'b000, 32'hFFFF_FFFF, 32'd1);
    set_req(1, 3'b000, 32'h10, 32'd1);
    set_req(2, 3'b000, 32'h20, 32'd1);
    set_req(3, 3'b000, 32'h30, 32'd1);
    rsp_ready = 1'b1;

    // Single add with carry out
    run_op(4'b0001, 0, 33'h1_0000_0000, 1'b0, 1'b1);

    // Round-robin saturation from a fresh pointer
    do_reset();
    run_op(4'b1111, 0, 33'h1_0000_0000, 1'b0, 1'b1);
    run_op(4'b1111, 1, 33'h11, 1'b0, 1'b0);
    run_op(4'b1111, 2, 33'h21, 1'b0, 1'b0);
    run_op(4'b1111, 3, 33'h31, 1'b0, 1'b0);
    run_op(4'b1111, 0, 33'h1_0000_0000, 1'b0, 1'b1);

    // Wrap fairness: ptr=1 -> grant 2, then 3, then wrap to 1
    run_op(4'b0100, 2, 33'h21, 1'b0, 1'b0);
    run_op(4'b1010, 3, 33'h31, 1'b0, 1'b0);
    run_op(4'b1010, 1, 33'h11, 1'b0, 1'b0);

    // Backpressure in RESP (ptr=2)
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    check("bp_grant", {60'd0, req_ready}, 64'h4);
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp_rsp_res", {31'd0, rsp_res}, 64'h21);
      check("bp_rsp_id", {62'd0, rsp_id}, 64'd2);
      check("bp_ready", {60'd0, req_ready}, 64'd0);
      check("bp_busy", {63'd0, busy}, 64'd1);
      cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_ack_ready", {60'd0, req_ready}, 64'd0);
    check("bp_ack_valid", {63'd0, rsp_valid}, 64'd1);
    cycle();
    @(negedge clk);
    check("bp_idle_valid", {63'd0, rsp_valid}, 64'd0);
    check("bp_idle_busy", {63'd0, busy}, 64'd0);
    check("bp_next_grant", {60'd0, req_ready}, 64'h8);
    cycle();
    req_valid = '0;
    @(negedge clk);
    check("bp_next_enable", {63'd0, alu_enable}, 64'd1);
    cycle();
    @(negedge clk);
    check("bp_next_id", {62'd0, rsp_id}, 64'd3);
    check("bp_next_res", {31'd0, rsp_res}, 64'h31);
    cycle();

    // Flags (ptr=0)
    set_req(0, 3'b001, 32'd5, 32'd5);
    set_req(1, 3'b011, 32'd0, 32'd0);
    set_req(2, 3'b111, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
    run_op(4'b0001, 0, 33'h0, 1'b1, 1'b0);
    run_op(4'b0010, 1, 33'h1_FFFF_FFFF, 1'b0, 1'b1);
    run_op(4'b0100, 2, 33'h0F0F_0F0F, 1'b0, 1'b0);

    // Reset mid-operation (ptr=3, so 0101 wins index 0 and leaves ptr=1)
    req_valid = 4'b0101;
    @(negedge clk);
    check("abort_grant", {60'd0, req_ready}, 64'h1);
    cycle();
    rst = 1'b1;
    @(negedge clk);
    check("abort_exec", {63'd0, alu_enable}, 64'd1);
    cycle();
    rst = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("abort_enable", {63'd0, alu_enable}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_regrant", {60'd0, req_ready}, 64'h1);
    cycle();
    req_valid = '0;
    @(negedge clk);
    check("abort_post_enable", {63'd0, alu_enable}, 64'd1);
    check("abort_post_op", {61'd0, alu_opcode}, 64'd1);
    cycle();
    @(negedge clk);
    check("abort_post_id", {62'd0, rsp_id}, 64'd0);
    check("abort_post_zf", {63'd0, rsp_zf}, 64'd1);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
